// File: rtl/fractal_sync_1d_local_ctrl.sv
// Per-port request/response controller around the 1D local barrier RF.
// Tracks waiting ports and issues a registered wake-up or error response.
module fractal_sync_1d_local_ctrl #(
    parameter int unsigned ID_WIDTH = 2,
    parameter int unsigned N_PORTS  = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [N_PORTS-1:0]                 req_valid_i,
    output logic [N_PORTS-1:0]                 req_ready_o,
    input  logic [N_PORTS-1:0][ID_WIDTH-1:0]   req_id_i,
    output logic [N_PORTS-1:0][ID_WIDTH-1:0]   rf_id_o,
    output logic [N_PORTS-1:0]                 rf_check_o,
    input  logic [N_PORTS-1:0]                 rf_present_i,
    input  logic [N_PORTS-1:0]                 rf_id_err_i,
    input  logic [N_PORTS-1:0]                 rf_bypass_i,
    input  logic [N_PORTS-1:0]                 rf_ignore_i,
    output logic [N_PORTS-1:0]                 resp_valid_o,
    input  logic [N_PORTS-1:0]                 resp_ready_i,
    output logic [N_PORTS-1:0][ID_WIDTH-1:0]   resp_id_o,
    output logic [N_PORTS-1:0]                 resp_err_o,
    output logic [$clog2(N_PORTS+1)-1:0]       n_waiting_o
);

    localparam int unsigned CNT_W = $clog2(N_PORTS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                             state_q [N_PORTS];
    state_e                             state_d [N_PORTS];
    logic [N_PORTS-1:0][ID_WIDTH-1:0]   id_q, id_d;
    logic [N_PORTS-1:0]                 err_q, err_d;
    logic [CNT_W-1:0]                   n_waiting_q, n_waiting_d;

    logic [N_PORTS-1:0]                 accept;
    logic [N_PORTS-1:0]                 pres_hit;
    logic [N_PORTS-1:0]                 wake;
    // hit[i][k]: the present verdict on requester i completes waiter k
    logic [N_PORTS-1:0][N_PORTS-1:0]    hit;

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            req_ready_o[i]  = (state_q[i] == IDLE);
            resp_valid_o[i] = (state_q[i] == RESP);
        end
    end

    assign accept      = req_valid_i & req_ready_o;
    assign rf_check_o  = accept;
    assign rf_id_o     = req_id_i;
    assign resp_id_o   = id_q;
    assign resp_err_o  = err_q;
    assign n_waiting_o = n_waiting_q;

    // Present only wakes waiters when no higher-priority verdict applies.
    assign pres_hit = accept & rf_present_i & ~rf_id_err_i & ~rf_bypass_i & ~rf_ignore_i;

    always_comb begin
        hit  = '0;
        wake = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            for (int k = 0; k < N_PORTS; k++) begin
                hit[i][k] = pres_hit[i] && (state_q[k] == WAIT) &&
                            (id_q[k][ID_WIDTH-1:1] == req_id_i[i][ID_WIDTH-1:1]);
                wake[k]   = wake[k] | hit[i][k];
            end
        end
    end

    always_comb begin
        id_d  = id_q;
        err_d = err_q;
        for (int i = 0; i < N_PORTS; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    if (accept[i]) begin
                        id_d[i]  = req_id_i[i];
                        err_d[i] = 1'b0;
                        if (rf_id_err_i[i]) begin
                            state_d[i] = RESP;
                            err_d[i]   = 1'b1;
                        end else if (rf_bypass_i[i] || rf_ignore_i[i] || rf_present_i[i]) begin
                            state_d[i] = RESP;
                        end else begin
                            state_d[i] = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wake[i]) begin
                        state_d[i] = RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i[i]) begin
                        state_d[i] = IDLE;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Counting the next state keeps n_waiting_o aligned with the visible states.
    always_comb begin
        n_waiting_d = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (state_d[i] == WAIT) begin
                n_waiting_d = n_waiting_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_PORTS; i++) begin
                state_q[i] <= IDLE;
            end
            id_q        <= '0;
            err_q       <= '0;
            n_waiting_q <= '0;
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                state_q[i] <= state_d[i];
            end
            id_q        <= id_d;
            err_q       <= err_d;
            n_waiting_q <= n_waiting_d;
        end
    end

    // RF reported a registered partner that no waiting port matches.
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_desync_chk
        a_present_has_waiter: assert property (
            @(posedge clk_i) disable iff (rst_i) pres_hit[gi] |-> (|hit[gi])
        );
    end

endmodule

// File: tb/tb_fractal_sync_1d_local_ctrl.sv
// Bench for fractal_sync_1d_local_ctrl: directed scenarios plus random traffic
// checked against a behavioural barrier model; the bench also plays the RF.
module tb_fractal_sync_1d_local_ctrl;

    localparam int N  = 4;
    localparam int W  = 2;
    localparam int CW = $clog2(N + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [N-1:0]          req_valid, req_ready, rf_check;
    logic [N-1:0][W-1:0]   req_id, rf_id, resp_id;
    logic [N-1:0]          rf_present, rf_id_err, rf_bypass, rf_ignore;
    logic [N-1:0]          resp_valid, resp_ready, resp_err;
    logic [CW-1:0]         n_waiting;

    int checks   = 0;
    int failures = 0;

    // Model: which ports wait on a barrier, which hold a response, and its content.
    bit          m_wait [N];
    bit          m_resp [N];
    bit          m_err  [N];
    logic [W-1:0] m_id  [N];

    fractal_sync_1d_local_ctrl #(.ID_WIDTH(W), .N_PORTS(N)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_id_i     (req_id),
        .rf_id_o      (rf_id),
        .rf_check_o   (rf_check),
        .rf_present_i (rf_present),
        .rf_id_err_i  (rf_id_err),
        .rf_bypass_i  (rf_bypass),
        .rf_ignore_i  (rf_ignore),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id),
        .resp_err_o   (resp_err),
        .n_waiting_o  (n_waiting)
    );

    function automatic bit m_busy(int p);
        return m_wait[p] || m_resp[p];
    endfunction

    function automatic int m_nwait();
        int c = 0;
        for (int p = 0; p < N; p++) c += int'(m_wait[p]);
        return c;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        for (int p = 0; p < N; p++) r[p] = !m_busy(p);
        return r;
    endfunction

    function automatic logic [N-1:0] m_valid();
        logic [N-1:0] r;
        for (int p = 0; p < N; p++) r[p] = m_resp[p];
        return r;
    endfunction

    // One clock of barrier semantics, from the inputs the bench is driving.
    task automatic model_step();
        bit          nw [N];
        bit          nr [N];
        bit          ne [N];
        logic [W-1:0] ni [N];
        if (rst) begin
            for (int p = 0; p < N; p++) begin
                m_wait[p] = 0; m_resp[p] = 0; m_err[p] = 0; m_id[p] = '0;
            end
            return;
        end
        for (int p = 0; p < N; p++) begin
            nw[p] = m_wait[p]; nr[p] = m_resp[p]; ne[p] = m_err[p]; ni[p] = m_id[p];
            if (m_resp[p] && resp_ready[p]) nr[p] = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && !m_busy(i)) begin
                ni[i] = req_id[i];
                ne[i] = 0;
                if (rf_id_err[i]) begin
                    nr[i] = 1; ne[i] = 1;
                end else if (rf_bypass[i] || rf_ignore[i]) begin
                    nr[i] = 1;
                end else if (rf_present[i]) begin
                    nr[i] = 1;
                    for (int k = 0; k < N; k++)
                        if (m_wait[k] && (m_id[k] >> 1) == (req_id[i] >> 1)) begin
                            nw[k] = 0; nr[k] = 1;
                        end
                end else begin
                    nw[i] = 1;
                end
            end
        end
        for (int p = 0; p < N; p++) begin
            m_wait[p] = nw[p]; m_resp[p] = nr[p]; m_err[p] = ne[p]; m_id[p] = ni[p];
        end
    endtask

    task automatic idle_inputs();
        req_valid  = '0;
        req_id     = '0;
        rf_present = '0;
        rf_id_err  = '0;
        rf_bypass  = '0;
        rf_ignore  = '0;
        resp_ready = '1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (req_ready !== '1) begin failures++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 4'b1111); end
        checks++; if (resp_valid !== '0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_err !== '0) begin failures++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
        checks++; if (resp_id !== '0) begin failures++; $display("FAIL reset_resp_id got=%h exp=0", resp_id); end
        checks++; if (n_waiting !== '0) begin failures++; $display("FAIL reset_n_waiting got=%0d exp=0", n_waiting); end
    endtask

    task automatic test_present_wake();
        idle_inputs();
        req_valid = 4'b0001; req_id[0] = 2'b10;
        #1;
        checks++; if (rf_check !== 4'b0001) begin failures++; $display("FAIL wake_check0 got=%b exp=0001", rf_check); end
        checks++; if (rf_id[0] !== 2'b10) begin failures++; $display("FAIL wake_rf_id0 got=%b exp=10", rf_id[0]); end
        tick();
        checks++; if (n_waiting !== CW'(1)) begin failures++; $display("FAIL wake_nwait1 got=%0d exp=1", n_waiting); end
        checks++; if (resp_valid !== 4'b0000) begin failures++; $display("FAIL wake_noresp got=%b exp=0000", resp_valid); end
        checks++; if (req_ready !== 4'b1110) begin failures++; $display("FAIL wake_ready got=%b exp=1110", req_ready); end
        idle_inputs();
        req_valid = 4'b0010; req_id[1] = 2'b10; rf_present = 4'b0010;
        #1;
        checks++; if (rf_check !== 4'b0010) begin failures++; $display("FAIL wake_check1 got=%b exp=0010", rf_check); end
        tick();
        checks++; if (resp_valid !== 4'b0011) begin failures++; $display("FAIL wake_resp got=%b exp=0011", resp_valid); end
        checks++; if (resp_id[0] !== 2'b10 || resp_id[1] !== 2'b10) begin failures++; $display("FAIL wake_ids got=%b,%b exp=10,10", resp_id[0], resp_id[1]); end
        checks++; if (resp_err[1:0] !== 2'b00) begin failures++; $display("FAIL wake_err got=%b exp=00", resp_err[1:0]); end
        checks++; if (n_waiting !== '0) begin failures++; $display("FAIL wake_nwait0 got=%0d exp=0", n_waiting); end
        idle_inputs();
        tick();
        checks++; if (resp_valid !== '0 || req_ready !== '1) begin failures++; $display("FAIL wake_idle got=%b/%b exp=0000/1111", resp_valid, req_ready); end
    endtask

    task automatic test_bypass_pair();
        idle_inputs();
        req_valid = 4'b0011; req_id[0] = 2'b10; req_id[1] = 2'b10;
        rf_bypass = 4'b0001; rf_ignore = 4'b0010;
        tick();
        checks++; if (resp_valid !== 4'b0011) begin failures++; $display("FAIL pair_resp got=%b exp=0011", resp_valid); end
        checks++; if (n_waiting !== '0) begin failures++; $display("FAIL pair_nwait got=%0d exp=0", n_waiting); end
        checks++; if (resp_id[0] !== 2'b10 || resp_id[1] !== 2'b10) begin failures++; $display("FAIL pair_ids got=%b,%b exp=10,10", resp_id[0], resp_id[1]); end
        checks++; if (resp_err[1:0] !== 2'b00) begin failures++; $display("FAIL pair_err got=%b exp=00", resp_err[1:0]); end
        idle_inputs();
        tick();
    endtask

    task automatic test_id_err();
        idle_inputs();
        req_valid = 4'b0001; req_id[0] = 2'b01;
        tick();
        idle_inputs();
        req_valid = 4'b0010; req_id[1] = 2'b11; rf_id_err = 4'b0010;
        tick();
        checks++; if (resp_valid !== 4'b0010) begin failures++; $display("FAIL err_resp got=%b exp=0010", resp_valid); end
        checks++; if (resp_err[1] !== 1'b1) begin failures++; $display("FAIL err_flag got=%b exp=1", resp_err[1]); end
        checks++; if (resp_id[1] !== 2'b11) begin failures++; $display("FAIL err_id got=%b exp=11", resp_id[1]); end
        checks++; if (n_waiting !== CW'(1) || req_ready[0] !== 1'b0) begin failures++; $display("FAIL err_port0 got=%0d/%b exp=1/0", n_waiting, req_ready[0]); end
        idle_inputs();
        tick();
    endtask

    // Port0 is still waiting on id 01 from the previous scenario.
    task automatic test_backpressure();
        idle_inputs();
        req_valid = 4'b0100; req_id[2] = 2'b00; rf_present = 4'b0100;
        resp_ready = 4'b1110;
        tick();
        checks++; if (resp_valid !== 4'b0101) begin failures++; $display("FAIL bp_wake got=%b exp=0101", resp_valid); end
        checks++; if (resp_id[0] !== 2'b01 || resp_id[2] !== 2'b00) begin failures++; $display("FAIL bp_ids got=%b,%b exp=01,00", resp_id[0], resp_id[2]); end
        idle_inputs();
        resp_ready = 4'b1110;
        req_valid = 4'b0001; req_id[0] = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (rf_check[0] !== 1'b0) begin failures++; $display("FAIL bp_no_accept cyc=%0d got=%b exp=0", c, rf_check[0]); end
            tick();
            checks++; if (resp_valid[0] !== 1'b1 || resp_id[0] !== 2'b01 || req_ready[0] !== 1'b0)
                begin failures++; $display("FAIL bp_hold cyc=%0d got=v%b id%b rdy%b exp=v1 id01 rdy0", c, resp_valid[0], resp_id[0], req_ready[0]); end
        end
        idle_inputs();
        tick();
        checks++; if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin failures++; $display("FAIL bp_release got=v%b rdy%b exp=v0 rdy1", resp_valid[0], req_ready[0]); end
    endtask

    task automatic test_quad();
        idle_inputs();
        req_valid = 4'b0101; req_id[0] = 2'b00; req_id[2] = 2'b10;
        tick();
        checks++; if (n_waiting !== CW'(2)) begin failures++; $display("FAIL quad_nwait2 got=%0d exp=2", n_waiting); end
        idle_inputs();
        req_valid = 4'b1010; req_id[1] = 2'b01; req_id[3] = 2'b11; rf_present = 4'b1010;
        tick();
        checks++; if (resp_valid !== 4'b1111) begin failures++; $display("FAIL quad_resp got=%b exp=1111", resp_valid); end
        checks++; if (resp_id !== 8'b11_10_01_00) begin failures++; $display("FAIL quad_ids got=%b exp=11100100", resp_id); end
        checks++; if (resp_err !== '0 || n_waiting !== '0) begin failures++; $display("FAIL quad_err_nwait got=%b/%0d exp=0000/0", resp_err, n_waiting); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        req_valid = 4'b0001; req_id[0] = 2'b10;
        tick();
        idle_inputs();
        req_valid = 4'b0010; req_id[1] = 2'b11; rf_bypass = 4'b0010; resp_ready = 4'b1101;
        tick();
        checks++; if (resp_valid !== 4'b0010 || n_waiting !== CW'(1)) begin failures++; $display("FAIL rstmid_setup got=%b/%0d exp=0010/1", resp_valid, n_waiting); end
        idle_inputs();
        resp_ready = '0;
        req_valid = 4'b0100; req_id[2] = 2'b10;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (req_ready !== '1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1111", req_ready); end
        checks++; if (resp_valid !== '0) begin failures++; $display("FAIL rstmid_resp got=%b exp=0000", resp_valid); end
        checks++; if (n_waiting !== '0) begin failures++; $display("FAIL rstmid_nwait got=%0d exp=0", n_waiting); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [N-1:0] exp_acc;
        bit waiter;
        int r;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(99) == 0);
            for (int p = 0; p < N; p++) begin
                req_valid[p]  = 1'($urandom_range(1));
                req_id[p]     = W'($urandom);
                resp_ready[p] = ($urandom_range(3) != 0);
                exp_acc[p]    = req_valid[p] && !m_busy(p);
                if (exp_acc[p]) begin
                    waiter = 0;
                    for (int k = 0; k < N; k++)
                        if (m_wait[k] && (m_id[k] >> 1) == (req_id[p] >> 1)) waiter = 1;
                    r = int'($urandom_range(3));
                    rf_id_err[p]  = ($urandom_range(7) == 0);
                    rf_present[p] = waiter;
                    rf_bypass[p]  = !waiter && r == 0;
                    rf_ignore[p]  = !waiter && r == 1;
                end else begin
                    rf_id_err[p]  = 1'($urandom_range(1));
                    rf_present[p] = 1'($urandom_range(1));
                    rf_bypass[p]  = 1'($urandom_range(1));
                    rf_ignore[p]  = 1'($urandom_range(1));
                end
            end
            #1;
            checks++; if (rf_check !== exp_acc) begin failures++; $display("FAIL rnd_check cyc=%0d got=%b exp=%b", c, rf_check, exp_acc); end
            checks++; if (rf_id !== req_id) begin failures++; $display("FAIL rnd_rf_id cyc=%0d got=%h exp=%h", c, rf_id, req_id); end
            tick();
            checks++; if (resp_valid !== m_valid()) begin failures++; $display("FAIL rnd_resp_valid cyc=%0d got=%b exp=%b", c, resp_valid, m_valid()); end
            checks++; if (req_ready !== m_ready()) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, req_ready, m_ready()); end
            checks++; if (int'(n_waiting) != m_nwait()) begin failures++; $display("FAIL rnd_nwait cyc=%0d got=%0d exp=%0d", c, n_waiting, m_nwait()); end
            for (int p = 0; p < N; p++) begin
                if (m_resp[p]) begin
                    checks++;
                    if (resp_id[p] !== m_id[p] || resp_err[p] !== m_err[p])
                        begin failures++; $display("FAIL rnd_resp_data cyc=%0d port=%0d got=%b/%b exp=%b/%b", c, p, resp_id[p], resp_err[p], m_id[p], m_err[p]); end
                end
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_present_wake();
        test_bypass_pair();
        test_id_err();
        test_backpressure();
        test_quad();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
